// File: rtl/key_filter.sv
// -----------------------------------------------------------------------------
// key_filter
//   Debounces and synchronises the raw push-button pins of the vending machine
//   (0.5 coin, 1.0 coin, spare/cancel). Each channel runs on its own and
//   produces a clean single-cycle press pulse plus a debounced "held" level.
//   key_flag[0]/[1]/[2] feed key1/key2/key3 of the downstream vending FSM.
//
// Parameters
//   CNT_MAX     filter count (999_999 = 20 ms at 50 MHz)
//   KEY_NUM     number of independent key channels
//   KEY_ACT_LOW 1: pin reads 0 when pressed, 0: pin reads 1 when pressed
//
// Ports
//   sclk       in   1        system clock
//   rst_n      in   1        asynchronous active-low reset
//   key_in     in   KEY_NUM  raw asynchronous button pins
//   key_flag   out  KEY_NUM  one-cycle pulse per debounced press
//   key_state  out  KEY_NUM  debounced level, 1 = held
// -----------------------------------------------------------------------------
module key_filter #(
  parameter int CNT_MAX     = 999_999,
  parameter int KEY_NUM     = 3,
  parameter bit KEY_ACT_LOW = 1'b1
) (
  input  logic               sclk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_flag,
  output logic [KEY_NUM-1:0] key_state
);

  localparam int              CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CW-1:0]   CNT_TOP = CW'(CNT_MAX);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);
  localparam logic [CW-1:0]   CNT_ZERO = CW'(0);
  // Pin level while the button is not pressed.
  localparam logic            REL_LVL = KEY_ACT_LOW;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILT_DN = 2'd1,
    DOWN    = 2'd2,
    FILT_UP = 2'd3
  } state_t;

  genvar g;
  generate
    for (g = 0; g < KEY_NUM; g++) begin : g_ch
      logic          sync1;
      logic          sync2;
      logic          pressed;
      state_t        state;
      logic [CW-1:0] cnt;
      logic          level_q;
      logic          flag_q;

      // Two-flop synchroniser; resets to the released level so no false press.
      always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
          sync1 <= REL_LVL;
          sync2 <= REL_LVL;
        end else begin
          sync1 <= key_in[g];
          sync2 <= sync1;
        end
      end

      // Active when the synchronised pin differs from its released level.
      assign pressed = sync2 ^ REL_LVL;

      // Debounce FSM with filter counter and registered outputs.
      always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
          state   <= IDLE;
          cnt     <= CNT_ZERO;
          level_q <= 1'b0;
          flag_q  <= 1'b0;
        end else begin
          // Held level follows the "debounced pressed" states one cycle later.
          level_q <= (state == DOWN) || (state == FILT_UP);
          // DOWN with level still low can only be the first cycle after
          // FILT_DN->DOWN; re-entry from FILT_UP keeps level high, so no repeat.
          flag_q  <= (state == DOWN) && !level_q;

          case (state)
            IDLE: begin
              cnt <= CNT_ZERO;
              if (pressed) begin
                state <= FILT_DN;
              end else begin
                state <= IDLE;
              end
            end
            FILT_DN: begin
              if (!pressed) begin
                state <= IDLE;
                cnt   <= CNT_ZERO;
              end else if (cnt == CNT_TOP) begin
                state <= DOWN;
                cnt   <= CNT_ZERO;
              end else begin
                state <= FILT_DN;
                cnt   <= cnt + CNT_ONE;
              end
            end
            DOWN: begin
              cnt <= CNT_ZERO;
              if (!pressed) begin
                state <= FILT_UP;
              end else begin
                state <= DOWN;
              end
            end
            FILT_UP: begin
              if (pressed) begin
                state <= DOWN;
                cnt   <= CNT_ZERO;
              end else if (cnt == CNT_TOP) begin
                state <= IDLE;
                cnt   <= CNT_ZERO;
              end else begin
                state <= FILT_UP;
                cnt   <= cnt + CNT_ONE;
              end
            end
            default: begin
              state <= IDLE;
              cnt   <= CNT_ZERO;
            end
          endcase
        end
      end

      assign key_flag[g]  = flag_q;
      assign key_state[g] = level_q;
    end
  endgenerate

endmodule

// File: tb/tb_key_filter.sv
// -----------------------------------------------------------------------------
// tb_key_filter
//   Self-checking bench for key_filter (CNT_MAX=15, active-low keys).
//   Reference model: per key, count consecutive samples that disagree with the
//   debounced level; CNT_MAX+2 of them in a row flip the level (a press also
//   gives a flag). Results become visible three sampling edges later.
// -----------------------------------------------------------------------------
module tb_key_filter;

  localparam int CNT_MAX  = 15;
  localparam int LAT      = CNT_MAX + 4;
  localparam int RUN_NEED = CNT_MAX + 2;

  logic       sclk  = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] key_in = 3'b111;
  logic [2:0] key_flag;
  logic [2:0] key_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // reference model state
  logic [2:0] m_d;
  int         m_run [3];
  logic [2:0] pf [3];
  logic [2:0] ps [3];
  logic [2:0] exp_flag;
  logic [2:0] exp_state;

  key_filter #(
    .CNT_MAX    (CNT_MAX),
    .KEY_NUM    (3),
    .KEY_ACT_LOW(1'b1)
  ) dut (
    .sclk     (sclk),
    .rst_n    (rst_n),
    .key_in   (key_in),
    .key_flag (key_flag),
    .key_state(key_state)
  );

  always #10 sclk = ~sclk;

  task automatic model_clear();
    m_d = 3'b000;
    for (int i = 0; i < 3; i++) begin
      m_run[i] = 0;
      pf[i]    = 3'b000;
      ps[i]    = 3'b000;
    end
    exp_flag  = 3'b000;
    exp_state = 3'b000;
  endtask

  // One clock: drive pins, let the edge sample them, update model, settle.
  task automatic step(input logic [2:0] k);
    logic [2:0] nf;
    key_in = k;
    @(posedge sclk);
    cyc++;
    if (!rst_n) begin
      model_clear();
    end else begin
      exp_flag  = pf[2];
      exp_state = ps[2];
      nf = 3'b000;
      for (int ch = 0; ch < 3; ch++) begin
        if ((~k[ch]) != m_d[ch]) m_run[ch]++;
        else m_run[ch] = 0;
        if (m_run[ch] == RUN_NEED) begin
          m_d[ch]   = ~m_d[ch];
          m_run[ch] = 0;
          nf[ch]    = m_d[ch];
        end
      end
      pf[2] = pf[1]; pf[1] = pf[0]; pf[0] = nf;
      ps[2] = ps[1]; ps[1] = ps[0]; ps[0] = m_d;
    end
    @(negedge sclk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(3'b111);
  endtask

  task automatic test_reset();
    model_clear();
    for (int i = 0; i < 3; i++) begin
      step(3'b111);
      checks++;
      if (key_flag !== 3'b000 || key_state !== 3'b000) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d flag=%b state=%b required=000/000", cyc, key_flag, key_state);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(3'b111);
      checks++;
      if (key_flag !== 3'b000 || key_state !== 3'b000) begin
        failures++;
        $display("FAIL idle_after_reset cyc=%0d flag=%b state=%b required=000/000", cyc, key_flag, key_state);
      end
    end
  endtask

  task automatic test_clean_press();
    int p, r, nfl, fc, drop;
    nfl = 0; fc = -1; drop = -1;
    p = cyc + 1;
    for (int i = 0; i < 100; i++) begin
      step(3'b110);
      checks++;
      if (key_flag !== exp_flag || key_state !== exp_state) begin
        failures++;
        $display("FAIL clean_model cyc=%0d flag=%b/%b state=%b/%b (got/required)", cyc, key_flag, exp_flag, key_state, exp_state);
      end
      if (key_flag[0] === 1'b1) begin nfl++; if (fc < 0) fc = cyc; end
    end
    r = cyc + 1;
    for (int i = 0; i < 30; i++) begin
      step(3'b111);
      checks++;
      if (key_flag !== exp_flag || key_state !== exp_state) begin
        failures++;
        $display("FAIL clean_rel_model cyc=%0d flag=%b/%b state=%b/%b (got/required)", cyc, key_flag, exp_flag, key_state, exp_state);
      end
      if (key_flag[0] === 1'b1) nfl++;
      if (key_state[0] === 1'b0 && drop < 0) drop = cyc;
    end
    checks++;
    if (fc != p + LAT) begin
      failures++;
      $display("FAIL clean_flag_latency got=%0d required=%0d", fc - p, LAT);
    end
    checks++;
    if (nfl != 1) begin
      failures++;
      $display("FAIL clean_flag_count got=%0d required=1", nfl);
    end
    checks++;
    if (drop != r + LAT) begin
      failures++;
      $display("FAIL clean_release_latency got=%0d required=%0d", drop - r, LAT);
    end
  endtask

  task automatic test_bounce_press();
    int seg_len [5];
    logic seg_lvl [5];
    int last, nfl, fc;
    seg_len = '{5, 3, 8, 1, 40};
    seg_lvl = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    nfl = 0; fc = -1; last = 0;
    for (int s = 0; s < 5; s++) begin
      if (s == 4) last = cyc + 1;
      for (int i = 0; i < seg_len[s]; i++) begin
        step({1'b1, seg_lvl[s], 1'b1});
        checks++;
        if (key_flag !== exp_flag || key_state !== exp_state) begin
          failures++;
          $display("FAIL bounce_model cyc=%0d flag=%b/%b state=%b/%b (got/required)", cyc, key_flag, exp_flag, key_state, exp_state);
        end
        if (key_flag[1] === 1'b1) begin nfl++; if (fc < 0) fc = cyc; end
      end
    end
    checks++;
    if (nfl != 1 || fc != last + LAT) begin
      failures++;
      $display("FAIL bounce_flag count=%0d offset=%0d required count=1 offset=%0d", nfl, fc - last, LAT);
    end
    idle(25);
  endtask

  task automatic test_release_bounce();
    int seg_len [3];
    logic seg_lvl [3];
    int fin, nfl, drop;
    seg_len = '{6, 4, 40};
    seg_lvl = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 30; i++) step(3'b110);
    nfl = 0; drop = -1; fin = 0;
    for (int s = 0; s < 3; s++) begin
      if (s == 2) fin = cyc + 1;
      for (int i = 0; i < seg_len[s]; i++) begin
        step({2'b11, seg_lvl[s]});
        checks++;
        if (key_flag !== exp_flag || key_state !== exp_state) begin
          failures++;
          $display("FAIL relbounce_model cyc=%0d flag=%b/%b state=%b/%b (got/required)", cyc, key_flag, exp_flag, key_state, exp_state);
        end
        if (key_flag[0] === 1'b1) nfl++;
        if (key_state[0] === 1'b0 && drop < 0) drop = cyc;
      end
    end
    checks++;
    if (nfl != 0) begin
      failures++;
      $display("FAIL relbounce_extra_flag got=%0d required=0", nfl);
    end
    checks++;
    if (drop != fin + LAT) begin
      failures++;
      $display("FAIL relbounce_drop got=%0d required=%0d", drop - fin, LAT);
    end
  endtask

  task automatic test_simultaneous();
    int p, fc0, fc1, bad2;
    fc0 = -1; fc1 = -1; bad2 = 0;
    p = cyc + 1;
    for (int i = 0; i < 40; i++) begin
      step(3'b100);
      checks++;
      if (key_flag !== exp_flag || key_state !== exp_state) begin
        failures++;
        $display("FAIL simul_model cyc=%0d flag=%b/%b state=%b/%b (got/required)", cyc, key_flag, exp_flag, key_state, exp_state);
      end
      if (key_flag[0] === 1'b1 && fc0 < 0) fc0 = cyc;
      if (key_flag[1] === 1'b1 && fc1 < 0) fc1 = cyc;
      if (key_flag[2] !== 1'b0 || key_state[2] !== 1'b0) bad2++;
    end
    checks++;
    if (fc0 != p + LAT || fc1 != p + LAT) begin
      failures++;
      $display("FAIL simul_flags k0=%0d k1=%0d required both=%0d", fc0 - p, fc1 - p, LAT);
    end
    checks++;
    if (bad2 != 0) begin
      failures++;
      $display("FAIL simul_key2_active got=%0d cycles required=0", bad2);
    end
    idle(25);
  endtask

  task automatic test_reset_mid_press();
    int rr, nfl, fc;
    nfl = 0; fc = -1;
    for (int i = 0; i < 10; i++) step(3'b110);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(3'b110);
      checks++;
      if (key_flag !== 3'b000 || key_state !== 3'b000) begin
        failures++;
        $display("FAIL midreset_outputs cyc=%0d flag=%b state=%b required=000/000", cyc, key_flag, key_state);
      end
    end
    rst_n = 1'b1;
    rr = cyc + 1;
    for (int i = 0; i < 40; i++) begin
      step(3'b110);
      checks++;
      if (key_flag !== exp_flag || key_state !== exp_state) begin
        failures++;
        $display("FAIL midreset_model cyc=%0d flag=%b/%b state=%b/%b (got/required)", cyc, key_flag, exp_flag, key_state, exp_state);
      end
      if (key_flag[0] === 1'b1) begin nfl++; if (fc < 0) fc = cyc; end
    end
    checks++;
    if (nfl != 1 || fc != rr + LAT) begin
      failures++;
      $display("FAIL midreset_flag count=%0d offset=%0d required count=1 offset=%0d", nfl, fc - rr, LAT);
    end
    idle(25);
  endtask

  task automatic test_glitch_train();
    int bad;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      step((i % 10 == 0) ? 3'b110 : 3'b111);
      if (key_flag !== 3'b000 || key_state !== 3'b000) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL glitch_train active_cycles=%0d required=0", bad);
    end
  endtask

  task automatic test_random();
    int rem [3];
    logic [2:0] k;
    k = 3'b111;
    for (int c = 0; c < 3; c++) rem[c] = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 3; c++) begin
        if (rem[c] == 0) begin
          k[c]   = $urandom_range(1, 0);
          rem[c] = $urandom_range(30, 1);
        end
        rem[c]--;
      end
      step(k);
      checks++;
      if (key_flag !== exp_flag || key_state !== exp_state) begin
        failures++;
        $display("FAIL random_model cyc=%0d flag=%b/%b state=%b/%b (got/required)", cyc, key_flag, exp_flag, key_state, exp_state);
      end
    end
    for (int i = 0; i < 25; i++) begin
      step(3'b111);
      checks++;
      if (key_flag !== exp_flag || key_state !== exp_state) begin
        failures++;
        $display("FAIL random_drain cyc=%0d flag=%b/%b state=%b/%b (got/required)", cyc, key_flag, exp_flag, key_state, exp_state);
      end
    end
  endtask

  initial begin
    @(negedge sclk);
    test_reset();
    test_clean_press();
    test_bounce_press();
    test_release_bounce();
    test_simultaneous();
    test_reset_mid_press();
    test_glitch_train();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
